// File: rtl/mem_arbiter_pkg.sv
// Shared defaults and FSM state encoding for the memory arbiter.
package mem_arbiter_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_HEIGHT = 16;
    localparam int DEF_PORTS  = 4;

    // IDLE: access register empty; ACCESS: access register holds a request
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter: the port after the last granted one has top priority.
module rr_arbiter #(
    parameter  int PORTS = 4,
    localparam int IDW   = $clog2(PORTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] req,
    input  logic             update,
    output logic [PORTS-1:0] grant,
    output logic [IDW-1:0]   grant_id
);

    logic [IDW-1:0] last;
    int             idx;
    logic           found;

    // Scan from last+1 upward with wrap; the first requesting port wins
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 1; k <= PORTS; k++) begin
            idx = (int'(last) + k) % PORTS;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = IDW'(idx);
                found      = 1'b1;
            end
        end
    end

    // Pointer moves only when the grant is actually taken; reset value
    // makes port 0 the first candidate
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last <= IDW'(PORTS - 1);
        else if (update)
            last <= grant_id;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-port round-robin arbiter in front of a single-port memory.
// One access register feeds the memory; grants refill it on the same edge
// an access finishes so back-to-back requests run without bubbles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter  int WIDTH  = DEF_WIDTH,
    parameter  int HEIGHT = DEF_HEIGHT,
    parameter  int PORTS  = DEF_PORTS,
    localparam int ADDR   = $clog2(HEIGHT),
    localparam int IDW    = $clog2(PORTS)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [PORTS-1:0]       req_valid_i,
    input  logic [PORTS-1:0]       req_isWrite_i,
    input  logic [PORTS*ADDR-1:0]  req_addr_i,
    input  logic [PORTS*WIDTH-1:0] req_wrData_i,
    output logic [PORTS-1:0]       req_ready_o,
    output logic [PORTS-1:0]       resp_valid_o,
    output logic [WIDTH-1:0]       resp_data_o,
    output logic                   enable_o,
    output logic                   isWrite_o,
    output logic [ADDR-1:0]        addr_o,
    output logic [WIDTH-1:0]       wrData_o,
    input  logic [WIDTH-1:0]       rdData_i,
    input  logic                   hold_i
);

    state_t state, next_state;

    // access register (valid bit is the ACCESS state)
    logic [IDW-1:0]   acc_id;
    logic             acc_wr;
    logic [ADDR-1:0]  acc_addr;
    logic [WIDTH-1:0] acc_data;

    // response stage
    logic             resp_pend;
    logic [IDW-1:0]   resp_id;
    logic             resp_wr;

    logic [PORTS-1:0] grant;
    logic [IDW-1:0]   grant_id;
    logic             finishing;
    logic             can_grant;
    logic             accept;
    int               sel;

    rr_arbiter #(.PORTS(PORTS)) u_rr (
        .clk      (clk_i),
        .rst      (rst_i),
        .req      (req_valid_i),
        .update   (accept),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // Handshake: grant only when the register is empty or draining this cycle;
    // reset masks ready so nothing is offered while the block is held in reset
    always_comb begin
        finishing   = (state == ACCESS) && !hold_i;
        can_grant   = !rst_i && ((state == IDLE) || finishing);
        req_ready_o = can_grant ? grant : '0;
        accept      = |req_ready_o;
        sel         = int'(grant_id);
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next state: a new grant keeps/puts us in ACCESS, a finish without one empties
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = ACCESS;
            ACCESS:  if (finishing) next_state = accept ? ACCESS : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Access register: load on grant, clear when draining into IDLE so the
    // memory outputs read as zero whenever no access is active
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_id   <= '0;
            acc_wr   <= 1'b0;
            acc_addr <= '0;
            acc_data <= '0;
        end else if (accept) begin
            acc_id   <= grant_id;
            acc_wr   <= req_isWrite_i[sel];
            acc_addr <= req_addr_i[sel*ADDR +: ADDR];
            acc_data <= req_isWrite_i[sel] ? req_wrData_i[sel*WIDTH +: WIDTH] : '0;
        end else if (finishing) begin
            acc_id   <= '0;
            acc_wr   <= 1'b0;
            acc_addr <= '0;
            acc_data <= '0;
        end
    end

    // Memory outputs come straight from the access register
    always_comb begin
        enable_o  = (state == ACCESS);
        isWrite_o = acc_wr;
        addr_o    = acc_addr;
        wrData_o  = acc_data;
    end

    // Response stage: remember who finished so the pulse lines up with rdData_i
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_pend <= 1'b0;
            resp_id   <= '0;
            resp_wr   <= 1'b0;
        end else begin
            resp_pend <= finishing;
            resp_id   <= acc_id;
            resp_wr   <= acc_wr;
        end
    end

    // One-hot completion pulse; read data passed through only for reads
    always_comb begin
        resp_valid_o = '0;
        if (resp_pend)
            resp_valid_o[resp_id] = 1'b1;
        resp_data_o = (resp_pend && !resp_wr) ? rdData_i : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle table for grant order/hold behaviour,
// hand sequences for read/write/reset corners, scoreboard on responses.
module tb_mem_arbiter;

    localparam int W = 16;
    localparam int H = 16;
    localparam int P = 4;
    localparam int A = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [P-1:0]   req_valid;
    logic [P-1:0]   req_iswr;
    logic [P*A-1:0] req_addr;
    logic [P*W-1:0] req_wrdata;
    logic [P-1:0]   req_ready;
    logic [P-1:0]   resp_valid;
    logic [W-1:0]   resp_data;
    logic           enable;
    logic           iswrite;
    logic [A-1:0]   addr;
    logic [W-1:0]   wrdata;
    logic [W-1:0]   rd_data;
    logic           hold;

    logic [A-1:0]   port_addr [P];
    logic [W-1:0]   port_data [P];

    int total = 0;
    int bad   = 0;

    typedef struct {
        int           port;
        logic [W-1:0] data;
    } sb_t;
    sb_t sb_q[$];

    logic [W-1:0] ref_mem [H];
    logic [W-1:0] mem [H];
    logic [W-1:0] rd_q;

    typedef struct {
        logic [3:0] v;
        logic [3:0] w;
        logic       h;
        logic [3:0] rdy;
        logic       en;
    } vec_t;
    vec_t tbl [21];

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(W), .HEIGHT(H), .PORTS(P)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_isWrite_i (req_iswr),
        .req_addr_i    (req_addr),
        .req_wrData_i  (req_wrdata),
        .req_ready_o   (req_ready),
        .resp_valid_o  (resp_valid),
        .resp_data_o   (resp_data),
        .enable_o      (enable),
        .isWrite_o     (iswrite),
        .addr_o        (addr),
        .wrData_o      (wrdata),
        .rdData_i      (rd_data),
        .hold_i        (hold)
    );

    function automatic logic [W-1:0] init_val(input logic [A-1:0] a);
        return (a == 4'd5) ? 16'hBEEF : (16'h1000 + {12'h000, a});
    endfunction

    always_comb begin
        req_addr   = '0;
        req_wrdata = '0;
        for (int p = 0; p < P; p++) begin
            req_addr[p*A +: A]   = port_addr[p];
            req_wrdata[p*W +: W] = port_data[p];
        end
    end

    // Memory model: read data valid the cycle after a finishing access
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < H; a++) mem[a] <= init_val(4'(a));
            rd_q <= '0;
        end else if (enable && !hold) begin
            if (iswrite) mem[addr] <= wrdata;
            else         rd_q <= mem[addr];
        end
    end
    assign rd_data = rd_q;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor, samples just before each rising edge
    always begin
        logic [3:0] oh;
        sb_t e;
        @(negedge clk);
        #4;
        if (rst) begin
            sb_q.delete();
            for (int a = 0; a < H; a++) ref_mem[a] = init_val(4'(a));
        end else begin
            if (resp_valid != '0) begin
                if (sb_q.size() == 0) begin
                    chk("resp_unexpected", 64'(resp_valid), 64'd0);
                end else begin
                    e  = sb_q.pop_front();
                    oh = 4'b0001 << e.port;
                    chk("sb_port", 64'(resp_valid), 64'(oh));
                    chk("sb_data", 64'(resp_data), 64'(e.data));
                end
            end
            chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
            for (int p = 0; p < P; p++) begin
                if (req_valid[p] && req_ready[p]) begin
                    e.port = p;
                    e.data = req_iswr[p] ? '0 : ref_mem[port_addr[p]];
                    if (req_iswr[p]) ref_mem[port_addr[p]] = port_data[p];
                    sb_q.push_back(e);
                end
            end
        end
    end

    task automatic cyc(input logic [3:0] v, input logic [3:0] w, input logic h);
        @(negedge clk);
        req_valid = v;
        req_iswr  = w;
        hold      = h;
        #2;
    endtask

    task automatic chk_idle_outs(input string name);
        chk(name, {req_ready, resp_valid, enable, iswrite, addr, wrdata, resp_data}, 64'd0);
    endtask

    initial begin
        rst = 1'b0;
        req_valid = '0;
        req_iswr  = '0;
        hold      = 1'b0;
        port_addr[0] = 4'd1; port_data[0] = 16'hAAAA;
        port_addr[1] = 4'd2; port_data[1] = 16'hBBBB;
        port_addr[2] = 4'd5; port_data[2] = 16'hCCCC;
        port_addr[3] = 4'd1; port_data[3] = 16'h3333;

        tbl[0]  = '{4'b1111, 4'b0000, 1'b0, 4'b0001, 1'b0};
        tbl[1]  = '{4'b1111, 4'b0000, 1'b0, 4'b0010, 1'b1};
        tbl[2]  = '{4'b1111, 4'b0000, 1'b0, 4'b0100, 1'b1};
        tbl[3]  = '{4'b1111, 4'b0000, 1'b0, 4'b1000, 1'b1};
        tbl[4]  = '{4'b1111, 4'b0000, 1'b0, 4'b0001, 1'b1};
        tbl[5]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1};
        tbl[6]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0};
        tbl[7]  = '{4'b1010, 4'b0000, 1'b0, 4'b0010, 1'b0};
        tbl[8]  = '{4'b1010, 4'b0000, 1'b1, 4'b0000, 1'b1};
        tbl[9]  = '{4'b1011, 4'b0000, 1'b1, 4'b0000, 1'b1};
        tbl[10] = '{4'b1010, 4'b0000, 1'b0, 4'b1000, 1'b1};
        tbl[11] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1};
        tbl[12] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0};
        tbl[13] = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b0};
        tbl[14] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1};
        tbl[15] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0};
        tbl[16] = '{4'b1000, 4'b1000, 1'b0, 4'b1000, 1'b0};
        tbl[17] = '{4'b1001, 4'b0000, 1'b0, 4'b0001, 1'b1};
        tbl[18] = '{4'b1001, 4'b0000, 1'b0, 4'b1000, 1'b1};
        tbl[19] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1};
        tbl[20] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0};

        // reset, with requests pending to make sure nothing is offered
        #1 rst = 1'b1;
        @(negedge clk);
        req_valid = 4'b1111;
        #2 chk_idle_outs("reset_hold");
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        #2 chk_idle_outs("reset_release");

        // grant order / hold / pointer table
        foreach (tbl[i]) begin
            cyc(tbl[i].v, tbl[i].w, tbl[i].h);
            chk($sformatf("tbl%0d_ready", i), 64'(req_ready), 64'(tbl[i].rdy));
            chk($sformatf("tbl%0d_en", i), 64'(enable), 64'(tbl[i].en));
        end

        // single read: port 2, addr 5
        cyc(4'b0100, 4'b0000, 1'b0);
        chk("rd_ready", 64'(req_ready), 64'h4);
        cyc(4'b0000, 4'b0000, 1'b0);
        chk("rd_mem", {enable, iswrite, addr, wrdata}, {1'b1, 1'b0, 4'd5, 16'h0});
        chk("rd_noresp_yet", 64'(resp_valid), 64'd0);
        cyc(4'b0000, 4'b0000, 1'b0);
        chk("rd_resp", {resp_valid, resp_data}, {4'b0100, 16'hBEEF});
        chk("rd_en_off", 64'(enable), 64'd0);

        // held write: port 1, addr 3, data 1234; port 0 waiting meanwhile
        port_addr[1] = 4'd3;
        port_data[1] = 16'h1234;
        cyc(4'b0010, 4'b0010, 1'b0);
        chk("wr_ready", 64'(req_ready), 64'h2);
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0001, 4'b0000, 1'b1);
            chk($sformatf("wr_hold%0d_mem", i), {enable, iswrite, addr, wrdata}, {1'b1, 1'b1, 4'd3, 16'h1234});
            chk($sformatf("wr_hold%0d_ready", i), 64'(req_ready), 64'd0);
            chk($sformatf("wr_hold%0d_resp", i), 64'(resp_valid), 64'd0);
        end
        cyc(4'b0000, 4'b0000, 1'b0);
        chk("wr_last_mem", {enable, iswrite, addr, wrdata}, {1'b1, 1'b1, 4'd3, 16'h1234});
        cyc(4'b0000, 4'b0000, 1'b0);
        chk("wr_resp", {resp_valid, resp_data}, {4'b0010, 16'h0});
        cyc(4'b0000, 4'b0000, 1'b0);
        chk("wr_resp_once", 64'(resp_valid), 64'd0);
        // read back through port 1, write data must not leak on a read
        cyc(4'b0010, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);
        chk("rb_mem", {enable, iswrite, addr, wrdata}, {1'b1, 1'b0, 4'd3, 16'h0});
        cyc(4'b0000, 4'b0000, 1'b0);
        chk("rb_resp", {resp_valid, resp_data}, {4'b0010, 16'h1234});

        // reset during a held access
        cyc(4'b0100, 4'b0000, 1'b0);
        chk("ab_ready", 64'(req_ready), 64'h4);
        cyc(4'b0000, 4'b0000, 1'b1);
        chk("ab_en", 64'(enable), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        req_valid = 4'b1111;
        #1 chk_idle_outs("ab_reset_now");
        @(negedge clk);
        #2 chk_idle_outs("ab_reset_next");
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        hold = 1'b0;
        #2 chk_idle_outs("ab_after");
        cyc(4'b1111, 4'b0000, 1'b0);
        chk("ab_grant_p0", 64'(req_ready), 64'h1);
        cyc(4'b0000, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);
        chk("ab_resp_p0", {resp_valid, resp_data}, {4'b0001, 16'h1001});
        cyc(4'b0000, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter HEIGHT, default 16, memory depth in words; ADDR = $clog2(HEIGHT).
REQ-003 Parameter PORTS, default 4, number of requesters, legal range 2..16; IDW = $clog2(PORTS).
REQ-004 clk_i  input  1  sole clock; all state on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 req_valid_i  input  PORTS  per-port request pending.
REQ-007 req_isWrite_i  input  PORTS  per-port access type, 1 = write.
REQ-008 req_addr_i  input  PORTS*ADDR  per-port word address, port i at slice [i*ADDR +: ADDR].
REQ-009 req_wrData_i  input  PORTS*WIDTH  per-port write data, port i at slice [i*WIDTH +: WIDTH].
REQ-010 req_ready_o  output  PORTS  one-hot-or-zero; request of port i accepted on the cycle req_valid_i[i] & req_ready_o[i].
REQ-011 resp_valid_o  output  PORTS  one-hot-or-zero completion pulse, one per accepted request.
REQ-012 resp_data_o  output  WIDTH  read data of the completing access, shared by all ports.
REQ-013 enable_o, isWrite_o  output  1 each  memory access active / access is a write.
REQ-014 addr_o  output  ADDR; wrData_o  output  WIDTH  memory address and write data.
REQ-015 rdData_i  input  WIDTH  memory read data, valid the cycle after an access finishes.
REQ-016 hold_i  input  1  memory stall; access held while enable_o & hold_i.

Function
REQ-017 Access register SHALL hold {valid, port id, isWrite, addr, wrData}; memory outputs driven only from it.
REQ-018 States: IDLE (register empty) and ACCESS (register full); finishing = ACCESS & ~hold_i.
REQ-019 Grant SHALL be issued when in IDLE or finishing, to the round-robin winner among req_valid_i; at most one req_ready_o bit set.
REQ-020 Round-robin: search starts at port (last granted + 1) mod PORTS, wrapping; pointer updates only on an accepted grant.
REQ-021 Accepted request SHALL appear on enable_o the next cycle (latency 1); back-to-back grants on finishing SHALL give zero idle cycles.
REQ-022 ACCESS with no grant on finishing SHALL return to IDLE; enable_o, isWrite_o, addr_o, wrData_o SHALL be 0 in IDLE.
REQ-023 wrData_o SHALL be 0 when isWrite_o is 0.
REQ-024 While hold_i is high in ACCESS, all memory outputs SHALL stay stable and req_ready_o SHALL be 0.
REQ-025 One cycle after finishing, resp_valid_o[id] SHALL pulse for exactly one cycle; resp_data_o = rdData_i for reads, 0 for writes and when no pulse.
REQ-026 hold_i while IDLE SHALL be ignored.
REQ-027 A port deasserting req_valid_i before grant SHALL not be granted; fields only sampled on grant cycle.

Reset
REQ-028 On rst_i: state IDLE, round-robin pointer so port 0 has top priority, response stage cleared.
REQ-029 During and after reset all outputs SHALL be 0 until a grant occurs.
REQ-030 Reset mid-access SHALL abort it with no resp_valid_o pulse for the aborted request.

Structure
REQ-031 Package mem_arbiter_pkg SHALL hold default WIDTH/HEIGHT/PORTS constants and the IDLE/ACCESS state enum.
REQ-032 One sub-module rr_arbiter (PORTS-wide request vector in, one-hot grant out, pointer update enable) SHALL implement REQ-020.

Verification
REQ-033 Single read: port 2 reads addr 5, memory holds 0xBEEF, hold_i=0 -> ready[2] cycle 0, enable_o cycle 1, resp_valid[2] and resp_data 0xBEEF cycle 2.
REQ-034 All 4 ports valid continuously, hold_i=0 -> grants in order 0,1,2,3,0, one per cycle, enable_o never drops.
REQ-035 Write port 1 addr 3 data 0x1234 with hold_i high 3 cycles -> outputs stable 4 cycles, resp_valid[1] once, resp_data 0; later read addr 3 returns 0x1234.
REQ-036 Ports 0 and 3 valid after port 3 last granted -> port 0 granted first, then port 3.
REQ-037 rst_i asserted while hold_i high mid-access -> outputs 0 immediately, no resp pulse, next grant to port 0.
